apuf_launch_ctrl: RTL

//  Initiator side of the arbiter-PUF race and the counterpart of the arbiter flip-flop.
//  Per request it:
//   - latches a challenge and drives it onto the delay-line selects;
//   - fires a launch edge into both race paths N_VOTES times;
//   - samples the arbiter output after each race and majority-votes the samples into one response bit.

---
 rtl/apuf_launch_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/apuf_launch_ctrl.sv
// Arbiter-PUF race initiator: applies a challenge, fires N_VOTES launch edges,
// samples the synchronized arbiter output per race and majority-votes a response bit.
module apuf_launch_ctrl #(
  parameter int CHAL_W     = 64,
  parameter int SETTLE_CYC = 16,
  parameter int N_VOTES    = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CHAL_W-1:0]            challenge,
  output logic                         busy,
  output logic [CHAL_W-1:0]            challenge_out,
  output logic                         launch,
  input  logic                         arb_q,
  output logic                         resp_valid,
  output logic                         resp,
  output logic [$clog2(N_VOTES+1)-1:0] ones_count
);

  localparam int PH_W = $clog2(SETTLE_CYC);
  localparam int VC_W = $clog2(N_VOTES+1);

  if ((N_VOTES % 2) == 0 || N_VOTES < 1) begin : g_bad_votes
    $error("apuf_launch_ctrl: N_VOTES must be odd and >= 1");
  end
  if (SETTLE_CYC < 3) begin : g_bad_settle
    $error("apuf_launch_ctrl: SETTLE_CYC must be >= 3");
  end

  typedef enum logic [2:0] {IDLE, APPLY, FIRE, RELAX, DONE} state_t;

  state_t            state, next_state;
  logic [PH_W-1:0]   phase;
  logic [VC_W-1:0]   vote_idx;
  logic [VC_W-1:0]   vote_next;
  logic              arb_q_p0, arb_q_p1;
  logic              phase_end;
  logic              timed;
  logic              accept;

  function automatic logic majority(input logic [VC_W-1:0] ones);
    return ones > VC_W'(N_VOTES / 2);
  endfunction

  assign phase_end = (phase == PH_W'(SETTLE_CYC - 1));
  assign timed     = (state == APPLY) || (state == FIRE) || (state == RELAX);
  assign vote_next = vote_idx + VC_W'(1);

  // Stage p0/p1: arbiter output crosses into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_q_p0 <= 1'b0;
      arb_q_p1 <= 1'b0;
    end else begin
      arb_q_p0 <= arb_q;
      arb_q_p1 <= arb_q_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = APPLY;
        end
      end
      APPLY: if (phase_end) next_state = FIRE;
      FIRE:  if (phase_end) next_state = RELAX;
      RELAX: begin
        if (phase_end) next_state = (vote_next == VC_W'(N_VOTES)) ? DONE : FIRE;
      end
      DONE: begin
        // A start seen while the response is presented begins the next run at once
        if (start) begin
          accept     = 1'b1;
          next_state = APPLY;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so launch never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase         <= '0;
      vote_idx      <= '0;
      ones_count    <= '0;
      challenge_out <= '0;
      launch        <= 1'b0;
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
      resp          <= 1'b0;
    end else begin
      phase      <= (next_state != state) ? '0 : (timed ? phase + PH_W'(1) : phase);
      launch     <= (next_state == FIRE);
      busy       <= (next_state == APPLY) || (next_state == FIRE) || (next_state == RELAX);
      resp_valid <= (next_state == DONE);
      if (accept) begin
        challenge_out <= challenge;
        ones_count    <= '0;
        vote_idx      <= '0;
      end
      if (state == FIRE && phase_end) ones_count <= ones_count + VC_W'(arb_q_p1);
      if (state == RELAX && phase_end) vote_idx <= vote_next;
      if (next_state == DONE) resp <= majority(ones_count);
    end
  end

endmodule
